// File: rtl/jkj_cda_pkg.sv
// Shared definitions for the carry-difference recovery block: FSM states,
// datapath width and the borrow seed that undoes the adder's +1.
package jkj_cda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int   DATA_W      = 8;
  localparam logic INIT_BORROW = 1'b1;

endpackage

// File: rtl/tt_um_jkj_cda_diff_if.sv
// Request/result bundle between the operand source/consumer and the
// difference-recovery block.
interface tt_um_jkj_cda_diff_if;
  import jkj_cda_pkg::*;

  logic              ena;
  logic [DATA_W-1:0] sum_in;
  logic [DATA_W-1:0] opa_in;
  logic              load;
  logic              ack;
  logic [DATA_W-1:0] diff_out;
  logic              valid;
  logic              busy;
  logic              wrap;

  modport master (
    output ena, sum_in, opa_in, load, ack,
    input  diff_out, valid, busy, wrap
  );

  modport slave (
    input  ena, sum_in, opa_in, load, ack,
    output diff_out, valid, busy, wrap
  );

endinterface

// File: rtl/tt_um_jkj_cda_diff_fsub_bit.sv
// One-bit full subtractor: d = s - a - bin, with the outgoing borrow.
module cda_fsub_bit (
  input  logic s,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = s ^ a ^ bin;
  assign bout = (~s & a) | (~(s ^ a) & bin);

endmodule

// File: rtl/tt_um_jkj_cda_diff.sv
// Bit-serial recovery of operand B from S = A + B + 1: computes S - A - 1
// LSB first over 8 enabled cycles and reports the final borrow as wrap.
module tt_um_jkj_cda_diff
  import jkj_cda_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  tt_um_jkj_cda_diff_if.slave   bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_t                 state;
  state_t                 state_nxt;

  logic [DATA_W-1:0]      s_sr;
  logic [DATA_W-1:0]      a_sr;
  logic [DATA_W-1:0]      d_sr;
  logic [DATA_W-1:0]      diff_q;
  logic [CNT_W-1:0]       cnt;
  logic                   bits_done;
  logic                   borrow;
  logic                   wrap_q;

  logic                   bit_d;
  logic                   bit_bout;

  cda_fsub_bit u_fsub (
    .s    (s_sr[0]),
    .a    (a_sr[0]),
    .bin  (borrow),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (bits_done) state_nxt = DONE;
      DONE:    if (bus.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: the cycle after the last bit publishes the result
  // into the output registers, so outputs never show a partial value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_sr      <= '0;
      a_sr      <= '0;
      d_sr      <= '0;
      diff_q    <= '0;
      cnt       <= '0;
      bits_done <= 1'b0;
      borrow    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (bus.ena) begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            s_sr      <= bus.sum_in;
            a_sr      <= bus.opa_in;
            cnt       <= '0;
            bits_done <= 1'b0;
            borrow    <= INIT_BORROW;
          end
        end
        SHIFT: begin
          if (!bits_done) begin
            s_sr   <= s_sr >> 1;
            a_sr   <= a_sr >> 1;
            d_sr   <= {bit_d, d_sr[DATA_W-1:1]};
            borrow <= bit_bout;
            if (cnt == CNT_LAST) begin
              bits_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            diff_q <= d_sr;
            wrap_q <= borrow;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff_out = diff_q;
  assign bus.wrap     = wrap_q;
  assign bus.valid    = (state == DONE);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_tt_um_jkj_cda_diff.sv
// Self-checking bench for tt_um_jkj_cda_diff: directed scenarios plus a
// randomized sweep against an arithmetic reference model.
module tb_tt_um_jkj_cda_diff;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tt_um_jkj_cda_diff_if bus ();

  tt_um_jkj_cda_diff dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] ref_diff(input int s, input int a);
    int r;
    r = (s - a - 1) % 256;
    if (r < 0) r += 256;
    return 8'(r);
  endfunction

  function automatic logic ref_wrap(input int s, input int a);
    return (s < a + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] a);
    bus.sum_in = s;
    bus.opa_in = a;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  // Counts edges until valid; -1 if it never rises within the budget.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.valid && n < 40) begin
      step();
      n++;
    end
    if (!bus.valid) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.ena = 1'b1; bus.load = 1'b1; bus.ack = 1'b1;
    bus.sum_in = 8'h10; bus.opa_in = 8'h05;
    step(); step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.diff_out !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", bus.diff_out); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", bus.wrap); end
    rst = 1'b0; bus.load = 1'b0; bus.ack = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n;
    launch(8'h10, 8'h05);
    wait_valid(n);
    total++; if (n !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", n); end
    total++; if (bus.diff_out !== 8'h0A) begin bad++; $display("FAIL basic_diff got=%h want=0a", bus.diff_out); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL basic_wrap got=%b want=0", bus.wrap); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
    step();
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL basic_valid_hold got=%b want=1", bus.valid); end
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL basic_ack_valid got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_ack_busy got=%b want=0", bus.busy); end
    total++; if (bus.diff_out !== 8'h0A) begin bad++; $display("FAIL basic_diff_hold got=%h want=0a", bus.diff_out); end
  endtask

  task automatic test_wrap();
    logic [7:0] sv [2];
    logic [7:0] av [2];
    int n;
    sv[0] = 8'h00; av[0] = 8'h00;
    sv[1] = 8'h05; av[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      launch(sv[i], av[i]);
      wait_valid(n);
      total++; if (n !== 9) begin bad++; $display("FAIL wrap_latency[%0d] got=%0d want=9", i, n); end
      total++; if (bus.diff_out !== ref_diff(sv[i], av[i])) begin bad++; $display("FAIL wrap_diff[%0d] got=%h want=%h", i, bus.diff_out, ref_diff(sv[i], av[i])); end
      total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL wrap_flag[%0d] got=%b want=1", i, bus.wrap); end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
    end
  endtask

  task automatic test_load_ignored();
    int n;
    launch(8'hFF, 8'hFE);
    step(); step();
    bus.sum_in = 8'h10; bus.opa_in = 8'h05; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_valid(n);
    total++; if (n !== 6) begin bad++; $display("FAIL ign_latency got=%0d want=6", n); end
    total++; if (bus.diff_out !== 8'h00) begin bad++; $display("FAIL ign_diff got=%h want=00", bus.diff_out); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL ign_wrap got=%b want=0", bus.wrap); end
    bus.load = 1'b1; bus.ack = 1'b1;
    step();
    bus.load = 1'b0; bus.ack = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_loadack_busy got=%b want=0", bus.busy); end
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_load_dropped got=%b want=0", bus.busy); end
    total++; if (bus.diff_out !== 8'h00) begin bad++; $display("FAIL ign_diff_hold got=%h want=00", bus.diff_out); end
  endtask

  task automatic test_ack_ignored();
    int n;
    bus.ack = 1'b1; step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ackidle_busy got=%b want=0", bus.busy); end
    bus.ack = 1'b0;
    launch(8'h80, 8'h01);
    bus.ack = 1'b1; step(); step(); step(); bus.ack = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ackshift_busy got=%b want=1", bus.busy); end
    wait_valid(n);
    total++; if (3 + n !== 9) begin bad++; $display("FAIL ackshift_latency got=%0d want=9", 3 + n); end
    total++; if (bus.diff_out !== 8'h7E) begin bad++; $display("FAIL ackshift_diff got=%h want=7e", bus.diff_out); end
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    launch(8'h37, 8'h12);
    step(); step();
    bus.ena = 1'b0;
    step(); step(); step();
    total++; if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin bad++; $display("FAIL stall_hold got busy=%b valid=%b want busy=1 valid=0", bus.busy, bus.valid); end
    bus.ena = 1'b1;
    wait_valid(n);
    total++; if (5 + n !== 12) begin bad++; $display("FAIL stall_latency got=%0d want=12", 5 + n); end
    total++; if (bus.diff_out !== 8'h24) begin bad++; $display("FAIL stall_diff got=%h want=24", bus.diff_out); end
    bus.ena = 1'b0; bus.ack = 1'b1;
    step();
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL stall_ack_frozen got=%b want=1", bus.valid); end
    bus.ena = 1'b1;
    step();
    bus.ack = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL stall_ack_resume got=%b want=0", bus.valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    launch(8'hA5, 8'h3C);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got busy=%b valid=%b want 0 0", bus.busy, bus.valid); end
    total++; if (bus.diff_out !== 8'h00 || bus.wrap !== 1'b0) begin bad++; $display("FAIL rstmid_data got diff=%h wrap=%b want 00 0", bus.diff_out, bus.wrap); end
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_resume got=%b want=0", bus.busy); end
    launch(8'h10, 8'h05);
    wait_valid(n);
    total++; if (n !== 9 || bus.diff_out !== 8'h0A) begin bad++; $display("FAIL rstmid_reload got lat=%0d diff=%h want 9 0a", n, bus.diff_out); end
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
  endtask

  task automatic test_random();
    int s, a, n, gap;
    for (int i = 0; i < 1000; i++) begin
      s = $urandom_range(0, 255);
      a = $urandom_range(0, 255);
      launch(8'(s), 8'(a));
      wait_valid(n);
      total++; if (n !== 9) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=9", i, n); end
      total++; if (bus.diff_out !== ref_diff(s, a)) begin bad++; $display("FAIL rand_diff it=%0d s=%h a=%h got=%h want=%h", i, s, a, bus.diff_out, ref_diff(s, a)); end
      total++; if (bus.wrap !== ref_wrap(s, a)) begin bad++; $display("FAIL rand_wrap it=%0d s=%h a=%h got=%b want=%b", i, s, a, bus.wrap, ref_wrap(s, a)); end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 1'b1; bus.load = 1'b0; bus.ack = 1'b0;
    bus.sum_in = 8'h00; bus.opa_in = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_load_ignored();
    test_ack_ignored();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_jkj_cda_diff.md
TT_UM_JKJ_CDA_DIFF -- requirements
Module: tt_um_jkj_cda_diff

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ena, input, 1; when high the block advances, when low all state holds.
REQ-005 SHALL have port sum_in, input, 8, the 8-bit sum S produced by the demo adder (S = A + B + 1 mod 256).
REQ-006 SHALL have port opa_in, input, 8, the known operand A.
REQ-007 SHALL have port load, input, 1; a request to capture sum_in and opa_in.
REQ-008 SHALL have port ack, input, 1; consumer acknowledgement of the result.
REQ-009 SHALL have port diff_out, output, 8, the recovered operand B = S - A - 1 mod 256.
REQ-010 SHALL have port valid, output, 1; high while diff_out holds a completed result.
REQ-011 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-012 SHALL have port wrap, output, 1, the final borrow; it is 1 when S < A + 1 as unsigned 9-bit values, meaning the adder wrapped.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with ena=1 and load=1, capture S and A into shift registers, clear the bit counter, set borrow=1, and enter SHIFT.
REQ-015 SHALL, in SHIFT with ena=1, process one bit per cycle, LSB first:
  - d = s ^ a ^ borrow
  - borrow' = (~s & a) | (~(s ^ a) & borrow)
  - d is shifted into the diff register MSB-first, so that after 8 shifts bit k sits at position k.
REQ-016 SHALL leave SHIFT after exactly 8 processed bits, with the counter at 0..7 and no wrap, and enter DONE.
REQ-017 SHALL, in DONE, drive valid=1, drive diff_out with the result, and drive wrap with the final borrow.
REQ-018 SHALL give a latency of 9 enabled edges: if load is sampled at edge N, valid=1 appears after edge N+9, with ena high throughout.
REQ-019 SHALL, in DONE with ena=1 and ack=1, clear valid at the next edge and return to IDLE; diff_out and wrap hold their values until the next capture.
REQ-020 SHALL ignore load in SHIFT and in DONE; this includes load and ack sampled high together in DONE, where the load is dropped and the block enters IDLE.
REQ-021 SHALL ignore ack outside DONE.
REQ-022 SHALL, with ena=0, hold all registers, the FSM state and the outputs; latency is extended by the number of stalled cycles.
REQ-023 SHALL compute all arithmetic modulo 256, with no saturation.

Reset
REQ-024 SHALL, on rst=1 at any clock edge and in any state (including mid-SHIFT), enter IDLE with diff_out=0, valid=0, busy=0, wrap=0, counter=0 and borrow=0.
REQ-025 SHALL give rst priority over ena, load and ack.
REQ-026 SHALL discard any in-progress operation on reset and produce no partial result.

Structure
REQ-027 SHALL take the following from the shared package jkj_cda_pkg: the FSM state enum (IDLE/SHIFT/DONE), the constant DATA_W=8, and the constant INIT_BORROW=1.
REQ-028 SHALL implement the one-bit full-subtractor in sub-module cda_fsub_bit (inputs s, a, bin; outputs d, bout), with the borrow register kept in the parent.
REQ-029 SHALL contain no combinational path from load or ack to any output.

Verification
REQ-030 SHALL cover: S=0x10, A=0x05, load pulse -> after 9 edges valid=1, diff_out=0x0A, wrap=0, busy=1; then ack -> valid=0, busy=0 next edge.
REQ-031 SHALL cover: S=0x00, A=0x00 -> diff_out=0xFF, wrap=1; and S=0x05, A=0xFF -> diff_out=0x05, wrap=1.
REQ-032 SHALL cover: S=0xFF, A=0xFE -> diff_out=0x00, wrap=0; a second load with S=0x10, A=0x05 pulsed during SHIFT is ignored and the result stays 0x00.
REQ-033 SHALL cover: ena held low for 3 cycles mid-SHIFT -> valid appears after 12 edges and the result is unchanged.
REQ-034 SHALL cover: rst asserted at the 4th SHIFT edge -> next cycle state IDLE and all outputs 0; a new load with S=0x10, A=0x05 then yields 0x0A.
REQ-035 SHALL cover: random S, A for 1000 iterations -> diff_out equals (S - A - 1) mod 256 and wrap equals (S < A + 1).
